// File: rtl/inst_fetch_axi.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_axi
//  Purpose  : Single-entry instruction fetch buffer backed by single-beat
//             AXI4 reads; at most one read outstanding.
//  Revision : 1.0  initial release
// ============================================================================
module inst_fetch_axi #(
    parameter logic [3:0]  ARID_VAL = 4'h0,
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        flush,
    output logic [31:0] inst_rdata,
    output logic        i_stall,
    output logic        inst_err,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state_q;
    logic        buf_valid_q;
    logic [29:0] buf_tag_q;
    logic [31:0] buf_data_q;
    logic        buf_err_q;
    logic        drop_q;
    logic [31:0] req_addr_q;
    logic        arvalid_q;
    logic        rready_q;

    logic        hit;
    logic        start_d;
    logic        beat_done_d;
    logic        buf_wr_d;

    assign hit         = buf_valid_q & (buf_tag_q == inst_addr[31:2]);
    assign start_d     = (state_q == IDLE) & inst_req & ~hit & ~flush;
    assign beat_done_d = (state_q == DATA) & rvalid & rlast;
    // A flush in the completing cycle has priority over the buffer fill.
    assign buf_wr_d    = beat_done_d & ~drop_q & ~flush;

    assign i_stall    = inst_req & ~hit;
    assign inst_rdata = hit ? buf_data_q : 32'h0;
    assign inst_err   = hit & buf_err_q;

    assign arid    = ARID_VAL;
    assign araddr  = req_addr_q;
    assign arlen   = 8'h00;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

    logic unused_ok;
    assign unused_ok = ^{rid, inst_addr[1:0], RESET_PC};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            buf_valid_q <= 1'b0;
            buf_tag_q   <= 30'h0;
            buf_data_q  <= 32'h0;
            buf_err_q   <= 1'b0;
            drop_q      <= 1'b0;
            req_addr_q  <= 32'h0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            if (flush) begin
                buf_valid_q <= 1'b0;
            end else if (buf_wr_d) begin
                buf_valid_q <= 1'b1;
                buf_tag_q   <= req_addr_q[31:2];
                buf_data_q  <= rdata;
                buf_err_q   <= (rresp != 2'b00);
            end

            case (state_q)
                IDLE: begin
                    if (start_d) begin
                        req_addr_q <= {inst_addr[31:2], 2'b00};
                        drop_q     <= 1'b0;
                        arvalid_q  <= 1'b1;
                        state_q    <= ADDR;
                    end
                end
                ADDR: begin
                    // The read is never abandoned; a flush only marks it stale.
                    if (flush) begin
                        drop_q <= 1'b1;
                    end
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (flush) begin
                        drop_q <= 1'b1;
                    end
                    if (rvalid & rlast) begin
                        rready_q <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_axi.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_axi
//  Purpose  : Self-checking bench for inst_fetch_axi with a simple AXI slave.
//  Revision : 1.0  initial release
// ============================================================================
module tb_inst_fetch_axi;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = 32'h0;
    logic        flush = 1'b0;
    logic [31:0] inst_rdata;
    logic        i_stall;
    logic        inst_err;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [3:0]  rid = 4'h0;
    logic [31:0] rdata = 32'h0;
    logic [1:0]  rresp = 2'b00;
    logic        rlast = 1'b0;
    logic        rvalid = 1'b0;
    logic        rready;

    int          n_pass = 0;
    int          n_total = 0;

    int          ar_count = 0;
    logic [31:0] ar_log[$];
    logic [31:0] last_araddr = 32'h0;
    logic [31:0] sl_addr = 32'h0;
    bit          sl_pend = 1'b0;
    int          sl_cnt = 0;
    int          cfg_rdelay = 0;
    logic [1:0]  cfg_rresp = 2'b00;
    bit          rand_mode = 1'b0;

    inst_fetch_axi #(.ARID_VAL(4'h0), .RESET_PC(32'hbfc0_0000)) dut (
        .clk(clk), .rst(rst), .inst_req(inst_req), .inst_addr(inst_addr),
        .flush(flush), .inst_rdata(inst_rdata), .i_stall(i_stall),
        .inst_err(inst_err), .arid(arid), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arvalid(arvalid),
        .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    // Memory image seen by the slave; 0xbfc00000 holds 0x24080001.
    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h9bc8_0001;
    endfunction

    // Advance one clock: sample handshakes, then update slave outputs after the edge.
    task automatic tick();
        logic        hs_ar;
        logic        hs_r;
        logic [31:0] a;
        hs_ar = arvalid & arready;
        hs_r  = rvalid & rready & rlast;
        a     = araddr;
        @(posedge clk);
        #1;
        if (hs_r) begin
            rvalid  = 1'b0;
            rlast   = 1'b0;
            rdata   = 32'h0;
            rresp   = 2'b00;
            sl_pend = 1'b0;
        end
        if (hs_ar) begin
            ar_count++;
            ar_log.push_back(a);
            last_araddr = a;
            sl_addr     = a;
            sl_pend     = 1'b1;
            sl_cnt      = rand_mode ? int'($urandom_range(0, 3)) : cfg_rdelay;
        end
        if (sl_pend && !rvalid) begin
            if (sl_cnt == 0) begin
                rvalid = 1'b1;
                rlast  = 1'b1;
                rdata  = mem(sl_addr);
                rresp  = rand_mode ? ((($urandom % 4) == 0) ? 2'b10 : 2'b00) : cfg_rresp;
            end else begin
                sl_cnt--;
            end
        end
        if (rand_mode) arready = $urandom_range(0, 1) == 1;
    endtask

    task automatic test_reset();
        #2;
        rst = 1'b0;
        inst_req = 1'b1;
        inst_addr = 32'hbfc0_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++; if (arvalid !== 1'b0) $display("FAIL reset_arvalid: got %b want 0", arvalid); else n_pass++;
        n_total++; if (rready !== 1'b0) $display("FAIL reset_rready: got %b want 0", rready); else n_pass++;
        n_total++; if (i_stall !== 1'b1) $display("FAIL reset_stall: got %b want 1", i_stall); else n_pass++;
        n_total++; if (inst_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", inst_rdata); else n_pass++;
        n_total++; if (inst_err !== 1'b0) $display("FAIL reset_err: got %b want 0", inst_err); else n_pass++;
        n_total++; if (araddr !== 32'h0) $display("FAIL reset_araddr: got %h want 0", araddr); else n_pass++;
        n_total++; if ({arid, arlen, arsize, arburst} !== {4'h0, 8'h00, 3'b010, 2'b01})
            $display("FAIL ar_fixed: got %h/%h/%b/%b want 0/00/010/01", arid, arlen, arsize, arburst); else n_pass++;
        inst_req = 1'b0;
        @(negedge clk);
        n_total++; if (i_stall !== 1'b0) $display("FAIL noreq_stall: got %b want 0", i_stall); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_first_miss();
        int base;
        base = ar_count;
        inst_req = 1'b1;
        inst_addr = 32'hbfc0_0000;
        arready = 1'b1;
        cfg_rdelay = 0;
        cfg_rresp = 2'b00;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_total++; if (i_stall !== 1'b1) $display("FAIL first_miss_stall c%0d: got %b want 1", c, i_stall); else n_pass++;
            if (c == 1) begin
                n_total++; if (arvalid !== 1'b1) $display("FAIL first_miss_arvalid: got %b want 1", arvalid); else n_pass++;
            end
            tick();
        end
        @(negedge clk);
        n_total++; if (i_stall !== 1'b0) $display("FAIL first_miss_done: got %b want 0", i_stall); else n_pass++;
        n_total++; if (inst_rdata !== 32'h2408_0001) $display("FAIL first_miss_data: got %h want 24080001", inst_rdata); else n_pass++;
        n_total++; if (ar_count - base !== 1) $display("FAIL first_miss_arcount: got %0d want 1", ar_count - base); else n_pass++;
        n_total++; if (last_araddr !== 32'hbfc0_0000) $display("FAIL first_miss_araddr: got %h want bfc00000", last_araddr); else n_pass++;
        tick();
    endtask

    task automatic test_hold_hit();
        int base;
        base = ar_count;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_total++; if (i_stall !== 1'b0 || arvalid !== 1'b0)
                $display("FAIL hold_hit c%0d: got stall=%b arvalid=%b want 0/0", c, i_stall, arvalid); else n_pass++;
            tick();
        end
        n_total++; if (ar_count !== base) $display("FAIL hold_hit_traffic: got %0d ARs want 0", ar_count - base); else n_pass++;
    endtask

    task automatic test_arready_stall();
        int base;
        int k;
        base = ar_count;
        arready = 1'b0;
        inst_addr = 32'h1000_0040;
        @(negedge clk);
        n_total++; if (i_stall !== 1'b1) $display("FAIL arstall_miss: got %b want 1", i_stall); else n_pass++;
        tick();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_total++; if (arvalid !== 1'b1 || araddr !== 32'h1000_0040 || i_stall !== 1'b1)
                $display("FAIL arstall_hold c%0d: got v=%b a=%h s=%b want 1/10000040/1", c, arvalid, araddr, i_stall); else n_pass++;
            tick();
        end
        arready = 1'b1;
        @(negedge clk);
        n_total++; if (arvalid !== 1'b1) $display("FAIL arstall_hs: got %b want 1", arvalid); else n_pass++;
        tick();
        n_total++; if (ar_count !== base + 1) $display("FAIL arstall_count: got %0d want 1", ar_count - base); else n_pass++;
        k = 0;
        @(negedge clk);
        while (i_stall && k < 20) begin tick(); @(negedge clk); k++; end
        n_total++; if (i_stall !== 1'b0 || inst_rdata !== mem(32'h1000_0040))
            $display("FAIL arstall_data: got s=%b d=%h want 0/%h", i_stall, inst_rdata, mem(32'h1000_0040)); else n_pass++;
        tick();
    endtask

    task automatic test_flush_data();
        int base;
        int k;
        base = ar_count;
        inst_addr = 32'h2000_0000;
        cfg_rdelay = 3;
        @(negedge clk); tick();
        @(negedge clk); tick();
        flush = 1'b1;
        @(negedge clk);
        n_total++; if (rready !== 1'b1) $display("FAIL flush_in_data: got rready=%b want 1", rready); else n_pass++;
        tick();
        flush = 1'b0;
        k = 0;
        while (ar_count < base + 2 && k < 30) begin
            @(negedge clk);
            n_total++; if (i_stall !== 1'b1) $display("FAIL flush_drop_stall: got %b want 1", i_stall); else n_pass++;
            tick();
            k++;
        end
        n_total++; if (ar_count !== base + 2 || last_araddr !== 32'h2000_0000)
            $display("FAIL flush_refetch: got n=%0d a=%h want 2/20000000", ar_count - base, last_araddr); else n_pass++;
        k = 0;
        @(negedge clk);
        while (i_stall && k < 20) begin tick(); @(negedge clk); k++; end
        n_total++; if (i_stall !== 1'b0 || inst_rdata !== mem(32'h2000_0000))
            $display("FAIL flush_final: got s=%b d=%h want 0/%h", i_stall, inst_rdata, mem(32'h2000_0000)); else n_pass++;
        tick();
    endtask

    task automatic test_flush_coincide();
        int k;
        inst_addr = 32'h3000_0000;
        cfg_rdelay = 0;
        @(negedge clk); tick();
        @(negedge clk); tick();
        flush = 1'b1;
        @(negedge clk);
        n_total++; if ((rvalid & rready) !== 1'b1) $display("FAIL coincide_beat: got %b want 1", rvalid & rready); else n_pass++;
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_total++; if (i_stall !== 1'b1 || inst_rdata !== 32'h0)
            $display("FAIL coincide_discard: got s=%b d=%h want 1/0", i_stall, inst_rdata); else n_pass++;
        k = 0;
        while (i_stall && k < 20) begin tick(); @(negedge clk); k++; end
        n_total++; if (inst_rdata !== mem(32'h3000_0000)) $display("FAIL coincide_refill: got %h want %h", inst_rdata, mem(32'h3000_0000)); else n_pass++;
        tick();
    endtask

    task automatic test_err();
        int k;
        cfg_rresp = 2'b10;
        inst_addr = 32'h0000_0004;
        k = 0;
        @(negedge clk);
        while (i_stall && k < 20) begin tick(); @(negedge clk); k++; end
        n_total++; if (inst_err !== 1'b1 || inst_rdata !== mem(32'h4))
            $display("FAIL err_hit: got e=%b d=%h want 1/%h", inst_err, inst_rdata, mem(32'h4)); else n_pass++;
        tick();
        inst_addr = 32'h0000_0007;
        cfg_rresp = 2'b00;
        @(negedge clk);
        n_total++; if (i_stall !== 1'b0 || inst_err !== 1'b1 || inst_rdata !== mem(32'h4))
            $display("FAIL err_lowbits: got s=%b e=%b d=%h want 0/1/%h", i_stall, inst_err, inst_rdata, mem(32'h4)); else n_pass++;
        tick();
        inst_addr = 32'h0000_0008;
        @(negedge clk);
        n_total++; if (inst_err !== 1'b0 || inst_rdata !== 32'h0)
            $display("FAIL err_miss: got e=%b d=%h want 0/0", inst_err, inst_rdata); else n_pass++;
        k = 0;
        while (i_stall && k < 20) begin tick(); @(negedge clk); k++; end
        n_total++; if (inst_err !== 1'b0 || inst_rdata !== mem(32'h8))
            $display("FAIL err_okay: got e=%b d=%h want 0/%h", inst_err, inst_rdata, mem(32'h8)); else n_pass++;
        tick();
    endtask

    task automatic test_addr_change();
        int base;
        int k;
        logic [31:0] a0;
        logic [31:0] a1;
        base = ar_count;
        cfg_rdelay = 2;
        inst_addr = 32'h0000_0100;
        @(negedge clk); tick();
        @(negedge clk); tick();
        inst_addr = 32'h0000_0200;
        k = 0;
        @(negedge clk);
        while (i_stall && k < 30) begin tick(); @(negedge clk); k++; end
        a0 = (ar_log.size() > base) ? ar_log[base] : 32'hffff_ffff;
        a1 = (ar_log.size() > base + 1) ? ar_log[base + 1] : 32'hffff_ffff;
        n_total++; if (ar_count !== base + 2) $display("FAIL chg_count: got %0d want 2", ar_count - base); else n_pass++;
        n_total++; if (a0 !== 32'h100 || a1 !== 32'h200) $display("FAIL chg_addrs: got %h,%h want 100,200", a0, a1); else n_pass++;
        n_total++; if (i_stall !== 1'b0 || inst_rdata !== mem(32'h200))
            $display("FAIL chg_data: got s=%b d=%h want 0/%h", i_stall, inst_rdata, mem(32'h200)); else n_pass++;
        tick();
    endtask

    task automatic test_random();
        bit          m_valid, m_err, m_ar, m_r, m_drop, n_ar, n_r, exp_hit;
        logic [29:0] m_tag;
        logic [31:0] m_data, m_addr;
        inst_req = 1'b0;
        flush = 1'b1;
        @(negedge clk); tick();
        flush = 1'b0;
        m_valid = 0; m_err = 0; m_ar = 0; m_r = 0; m_drop = 0;
        m_tag = '0; m_data = '0; m_addr = '0;
        rand_mode = 1'b1;
        for (int c = 0; c < 400; c++) begin
            inst_req = ($urandom % 4) != 0;
            flush    = ($urandom % 16) == 0;
            if (($urandom % 3) == 0) begin
                case ($urandom % 4)
                    0: inst_addr = 32'h100;
                    1: inst_addr = 32'h104;
                    2: inst_addr = 32'h200;
                    default: inst_addr = $urandom;
                endcase
                inst_addr[1:0] = 2'($urandom % 4);
            end
            @(negedge clk);
            exp_hit = m_valid && (m_tag == inst_addr[31:2]);
            n_total++; if (i_stall !== (inst_req && !exp_hit)) $display("FAIL rnd_stall c%0d: got %b want %b", c, i_stall, inst_req && !exp_hit); else n_pass++;
            n_total++; if (inst_rdata !== (exp_hit ? m_data : 32'h0) || inst_err !== (exp_hit && m_err))
                $display("FAIL rnd_out c%0d: got %h/%b want %h/%b", c, inst_rdata, inst_err, exp_hit ? m_data : 32'h0, exp_hit && m_err); else n_pass++;
            n_total++; if (arvalid !== m_ar || rready !== m_r)
                $display("FAIL rnd_axi c%0d: got ar=%b r=%b want %b/%b", c, arvalid, rready, m_ar, m_r); else n_pass++;
            if (m_ar) begin
                n_total++; if (araddr !== m_addr) $display("FAIL rnd_araddr c%0d: got %h want %h", c, araddr, m_addr); else n_pass++;
            end
            // Expected buffer and outstanding-read bookkeeping for the coming edge.
            n_ar = m_ar;
            n_r  = m_r;
            if ((m_ar || m_r) && flush) m_drop = 1;
            if (m_ar && arready) begin
                n_ar = 0;
                n_r  = 1;
            end else if (m_r && rvalid && rlast) begin
                n_r = 0;
                if (!m_drop && !flush) begin
                    m_valid = 1;
                    m_tag   = m_addr[31:2];
                    m_data  = mem(m_addr);
                    m_err   = (rresp != 2'b00);
                end
            end else if (!m_ar && !m_r && inst_req && !exp_hit && !flush) begin
                n_ar   = 1;
                m_addr = {inst_addr[31:2], 2'b00};
                m_drop = 0;
            end
            if (flush) m_valid = 0;
            m_ar = n_ar;
            m_r  = n_r;
            tick();
        end
        rand_mode = 1'b0;
        flush = 1'b0;
        arready = 1'b1;
    endtask

    task automatic test_reset_mid();
        int k;
        cfg_rdelay = 5;
        cfg_rresp = 2'b00;
        inst_req = 1'b1;
        inst_addr = 32'h4000_0000;
        k = 0;
        @(negedge clk);
        while (!rready && k < 20) begin tick(); @(negedge clk); k++; end
        rst = 1'b0;
        sl_pend = 1'b0;
        rvalid = 1'b0;
        rlast = 1'b0;
        #1;
        n_total++; if (arvalid !== 1'b0 || rready !== 1'b0 || i_stall !== 1'b1)
            $display("FAIL midreset: got ar=%b r=%b s=%b want 0/0/1", arvalid, rready, i_stall); else n_pass++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        inst_addr = 32'h0000_0100;
        @(negedge clk);
        n_total++; if (i_stall !== 1'b1) $display("FAIL post_reset_miss: got %b want 1", i_stall); else n_pass++;
        k = 0;
        while (i_stall && k < 20) begin tick(); @(negedge clk); k++; end
        n_total++; if (i_stall !== 1'b0 || inst_rdata !== mem(32'h100))
            $display("FAIL post_reset_fill: got s=%b d=%h want 0/%h", i_stall, inst_rdata, mem(32'h100)); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_miss();
        test_hold_hit();
        test_arready_stall();
        test_flush_data();
        test_flush_coincide();
        test_err();
        test_addr_change();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/inst_fetch_axi.md
INST_FETCH_AXI -- requirements
Module: inst_fetch_axi

Interface
REQ-001 The block SHALL have parameter ARID_VAL, default 4'h0, the constant AXI read ID driven on arid.
REQ-002 The block SHALL have parameter RESET_PC, default 32'hbfc0_0000, informational only and not used for buffer tagging.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 inst_req  input  1  core requests the instruction at inst_addr this cycle.
REQ-006 inst_addr  input  32  fetch address, driven from pcF.
REQ-007 flush  input  1  exception/redirect; discards any in-flight fetch result.
REQ-008 inst_rdata  output  32  instruction word for inst_addr, driven to instrF.
REQ-009 i_stall  output  1  fetch not ready; ORed by the core into mips_stall.
REQ-010 inst_err  output  1  the returned word carried a non-OKAY rresp.
REQ-011 arid/araddr/arlen/arsize/arburst/arvalid  output  4/32/8/3/2/1  AXI read address channel.
REQ-012 arready  input  1  AXI read address ready.
REQ-013 rid/rdata/rresp/rlast/rvalid  input  4/32/2/1/1  AXI read data channel.
REQ-014 rready  output  1  AXI read data ready.

Function
REQ-015 The block SHALL hold a one-entry buffer: buf_valid, buf_tag[29:0], buf_data[31:0], buf_err.
REQ-016 hit SHALL be buf_valid & (buf_tag == inst_addr[31:2]), computed combinationally.
REQ-017 i_stall SHALL be inst_req & ~hit, combinational; i_stall SHALL be 0 whenever inst_req=0.
REQ-018 inst_rdata SHALL be buf_data and inst_err SHALL be buf_err when hit, else 32'h0 and 0.
REQ-019 FSM states SHALL be IDLE, ADDR, DATA.
REQ-020 IDLE: when inst_req & ~hit & ~flush, latch req_addr = {inst_addr[31:2],2'b00}, clear drop flag, and go to ADDR next cycle.
REQ-021 ADDR: arvalid=1, araddr=req_addr, which SHALL be stable until the handshake; on arvalid&arready go to DATA.
REQ-022 DATA: rready=1; on rvalid&rlast, if drop=0 write buf_tag=req_addr[31:2], buf_data=rdata, buf_err=(rresp!=2'b00), buf_valid=1; go to IDLE in either case.
REQ-023 Fixed AR fields SHALL be arid=ARID_VAL, arlen=0, arsize=3'b010, arburst=2'b01.
REQ-024 arvalid SHALL be 0 outside ADDR and rready SHALL be 0 outside DATA.
REQ-025 Only one AXI read SHALL be outstanding; no new AR until the R beat of the previous read completes.
REQ-026 flush in ADDR or DATA SHALL set drop=1, and the transaction SHALL still complete on AXI without abort.
REQ-027 flush in any state SHALL clear buf_valid on the next edge.
REQ-028 If flush and buffer write coincide in DATA, flush SHALL win and buf_valid SHALL end 0.
REQ-029 If inst_addr changes while in ADDR or DATA, the in-flight read SHALL finish for req_addr; on return to IDLE the new address misses and a new read SHALL start.
REQ-030 Minimum miss latency with arready=1 and rvalid one cycle after the AR handshake: req seen at cycle 0, arvalid at 1, rvalid at 2, buffer written at the end of 2, i_stall=0 at 3.
REQ-031 When the core holds inst_addr constant during a stall that has another cause, a hit SHALL persist with no extra AXI traffic.
REQ-032 inst_addr[1:0] SHALL be ignored for tagging and addressing.

Reset
REQ-033 While rst=0: state=IDLE, buf_valid=0, buf_tag=0, buf_data=0, buf_err=0, drop=0, req_addr=0, arvalid=0, rready=0.
REQ-034 Deassertion of rst SHALL be consumed synchronously; the first request after reset SHALL miss.
REQ-035 Reset asserted mid-transaction SHALL return to IDLE immediately; the AXI slave is reset on the same rst.

Verification
REQ-036 Case: after reset, inst_req=1, inst_addr=32'hbfc0_0000, arready=1, rvalid one cycle after AR with rdata=32'h2408_0001. Required: i_stall=1 for 3 cycles, then inst_rdata=32'h2408_0001, i_stall=0, exactly one AR with araddr=32'hbfc0_0000.
REQ-037 Case: held hit at 32'hbfc0_0000 for 10 cycles. Required: i_stall=0 throughout and no arvalid.
REQ-038 Case: arready held low for 5 cycles in ADDR. Required: arvalid=1 and araddr constant for all 5 cycles; handshake on cycle 6; i_stall=1 throughout.
REQ-039 Case: flush during DATA, then rvalid=1. Required: data discarded, buf_valid=0, the same address re-fetched with a second AR.
REQ-040 Case: rresp=2'b10 on a miss at 32'h0000_0004. Required: inst_err=1 while hit, inst_rdata equals rdata.
REQ-041 Case: inst_addr changes from 32'h100 to 32'h200 during DATA. Required: first AR=32'h100 completes; a second AR=32'h200 is issued; i_stall clears only once 32'h200 data returns.
